divide_arbiter: RTL
===================

Name: divide_arbiter

Overview:
- Shares one Divide datapath (start/finish pulse handshake; quotient/remainder valid in the finish cycle) between N requesters, e.g. the gcd engine and the modular-reduction step of the RSA core.
- Round-robin arbitration; latches the winner's operands, sequences the divider start pulse, returns the result with a per-requester done pulse.
- Measures divider latency per operation so the timing side-channel harness can log it.

Parameters:
- WIDTH, 8, operand/result width (matches the Divide instance).
- N_REQ, 2, number of requesters (≥2).
- CNT_W, 16, width of the latency counter (saturating).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester request level
- req_dividend  input  N_REQ*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
- req_divisor  input  N_REQ*WIDTH  packed divisors, same packing
- gnt  output  N_REQ  one-hot, one-cycle pulse: operands captured
- done  output  N_REQ  one-hot, one-cycle pulse: result valid
- quotient  output  WIDTH  result of the last completed operation
- remainder  output  WIDTH  result of the last completed operation
- div_zero  output  1  last completed operation had divisor==0
- last_cycles  output  CNT_W  div_start-to-div_finish cycles of the last operation
- busy  output  1  high in every state except IDLE
- div_start  output  1  one-cycle start pulse to Divide
- div_dividend  output  WIDTH  registered operand to Divide
- div_divisor  output  WIDTH  registered operand to Divide
- div_quotient  input  WIDTH  from Divide
- div_remainder  input  WIDTH  from Divide
- div_finish  input  1  from Divide, one-cycle pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer 0; owner 0; counter 0.
- States:
  - IDLE: if req≠0, pick the first set bit at or after the pointer (wrapping), latch its operands into div_dividend/div_divisor, latch owner, pulse gnt[owner] next cycle. Divisor≠0 → ISSUE; divisor==0 → RESP.
  - ISSUE (1 cycle): div_start=1, counter cleared to 1 → WAIT.
  - WAIT: counter increments each cycle, saturating at all-ones. On div_finish, capture div_quotient, div_remainder and the counter into last_cycles; div_zero=0 → RESP.
  - RESP (1 cycle): done[owner]=1; pointer ← (owner+1) mod N_REQ → IDLE.
- Divide-by-zero: no div_start is issued; quotient = all-ones, remainder = latched dividend, div_zero=1, last_cycles=0.
- Latency, no-zero case: req sampled at edge E. gnt is visible in cycle E+1, div_start in cycle E+1, done one cycle after the div_finish cycle. Next grant is no earlier than the cycle after done.
- Requesters deassert req in the cycle after seeing gnt. A req still high when the arbiter returns to IDLE is a new operation.
- Operands are sampled only at the grant edge; later changes are ignored.
- quotient, remainder, div_zero and last_cycles hold until the next RESP.
- A div_finish outside WAIT is ignored.
- Simultaneous requests: strict rotation; no requester waits more than N_REQ-1 operations.
- Reset mid-operation clears everything asynchronously. The Divide shares rst_n, so no stale finish survives.
- div_dividend/div_divisor stay stable from ISSUE through the finish cycle.

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, WAIT, RESP) and the divide-by-zero quotient constant.
- One sub-module: rr_select, a combinational round-robin picker (req, pointer → one-hot winner + index), reused by later schedulers.
- The Divide instance lives in the parent, not inside this block.

Test Plan:
- Single op: req=01, r0 dividend=100, divisor=7 → gnt=01, one div_start, done=01, quotient=14, remainder=2, div_zero=0, last_cycles = measured divider latency.
- Contention: req=11 from reset, pointer 0 → r0 served first, then r1 without r1 dropping req. Repeated, grants alternate 0,1,0,1.
- Divide by zero: r1 dividend=45, divisor=0 → no div_start, done=10 two cycles after grant, quotient=8'hFF, remainder=45, div_zero=1, last_cycles=0.
- Operand stability: r0 changes req_dividend from 100 to 3 after gnt → result still 14/2, div_dividend constant until finish.
- Reset in WAIT: assert rst_n=0 mid-operation → all outputs 0 immediately. After release, a fresh req=01 completes normally with no spurious done.
- Spurious finish: div_finish pulsed in IDLE → no done, outputs unchanged.

Source files
------------

// File: rtl/divide_arbiter_pkg.sv
// Shared types and constants for the divide arbiter: FSM encoding and the
// result pattern returned for a divide-by-zero request.
package divide_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Replicated across the quotient width: divide-by-zero reports all-ones.
    localparam logic DIV0_Q_BIT = 1'b1;

    function automatic int next_rr(input int owner, input int n);
        return (owner + 1 >= n) ? 0 : owner + 1;
    endfunction

endpackage

// File: rtl/divide_arbiter_if.sv
// Requester-side and divider-side signals of the divide arbiter, with the
// arbiter (master) and environment (slave) views.
interface divide_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
);
    import divide_arbiter_pkg::*;

    // Requesters hold req level-high until they see their one-cycle gnt pulse;
    // gnt means operands were captured, done means the result outputs are valid.
    // The divider sees a one-cycle div_start and answers with a one-cycle div_finish.
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_dividend;
    logic [N_REQ*WIDTH-1:0] req_divisor;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_zero;
    logic [CNT_W-1:0]       last_cycles;
    logic                   busy;
    logic                   div_start;
    logic [WIDTH-1:0]       div_dividend;
    logic [WIDTH-1:0]       div_divisor;
    logic [WIDTH-1:0]       div_quotient;
    logic [WIDTH-1:0]       div_remainder;
    logic                   div_finish;
    state_e                 dbg_state;

    modport master (
        input  req, req_dividend, req_divisor,
        input  div_quotient, div_remainder, div_finish,
        output gnt, done, quotient, remainder, div_zero, last_cycles, busy,
        output div_start, div_dividend, div_divisor, dbg_state
    );

    modport slave (
        output req, req_dividend, req_divisor,
        output div_quotient, div_remainder, div_finish,
        input  gnt, done, quotient, remainder, div_zero, last_cycles, busy,
        input  div_start, div_dividend, div_divisor, dbg_state
    );

endinterface

// File: rtl/divide_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping, returned both one-hot and as an index.
module rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int c;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            if (!valid_o && req_i[IDX_W'(c)]) begin
                valid_o            = 1'b1;
                idx_o              = IDX_W'(c);
                gnt_o[IDX_W'(c)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divide_arbiter.sv
// Round-robin sharing of one Divide datapath between N_REQ requesters, with
// per-operation divider latency measurement and a divide-by-zero bypass.
module divide_arbiter
    import divide_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    divide_arbiter_if.master bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               zero_q, zero_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               divz_q, divz_d;
    logic [CNT_W-1:0]   last_q, last_d;

    logic [N_REQ-1:0]   sel_gnt;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [N_REQ-1:0]   owner_oh;

    rr_select #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (sel_gnt),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_gnt[i]) begin
                op_a = bus.req_dividend[i*WIDTH +: WIDTH];
                op_b = bus.req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        zero_d     = zero_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        done_d     = '0;
        start_d    = 1'b0;
        quo_d      = quo_q;
        rem_d      = rem_q;
        divz_d     = divz_q;
        last_d     = last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    owner_d    = sel_idx;
                    dividend_d = op_a;
                    divisor_d  = op_b;
                    gnt_d      = sel_gnt;
                    if (op_b != '0) begin
                        start_d = 1'b1;
                        zero_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        zero_d  = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Result registers load on the finish edge so done and data appear together in RESP.
                if (bus.div_finish) begin
                    quo_d   = bus.div_quotient;
                    rem_d   = bus.div_remainder;
                    last_d  = cnt_q;
                    divz_d  = 1'b0;
                    done_d  = owner_oh;
                    state_d = ST_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // A zero divisor never reached the divider; its result is produced here instead.
                if (zero_q) begin
                    quo_d  = {WIDTH{DIV0_Q_BIT}};
                    rem_d  = dividend_q;
                    divz_d = 1'b1;
                    last_d = '0;
                    done_d = owner_oh;
                end
                ptr_d   = IDX_W'(next_rr(int'(owner_q), N_REQ));
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            start_q    <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            divz_q     <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            zero_q     <= zero_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            start_q    <= start_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            divz_q     <= divz_d;
            last_q     <= last_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.quotient     = quo_q;
    assign bus.remainder    = rem_q;
    assign bus.div_zero     = divz_q;
    assign bus.last_cycles  = last_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.div_start    = start_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.dbg_state    = state_q;

endmodule
